// File: rtl/rps_pkg.sv
// Shared encodings for the stone-paper-scissors match controller:
// move codes, round-result codes and the controller state enum.
package rps_pkg;

  typedef logic [1:0] move_t;
  localparam move_t MOVE_STONE    = 2'b00;
  localparam move_t MOVE_PAPER    = 2'b01;
  localparam move_t MOVE_SCISSORS = 2'b10;
  localparam move_t MOVE_ILLEGAL  = 2'b11;

  // Also used as the winner code once the match is done.
  typedef logic [1:0] res_t;
  localparam res_t RES_DRAW = 2'b00;
  localparam res_t RES_P1   = 2'b01;
  localparam res_t RES_P2   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_JUDGE,
    ST_REPORT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: two legal moves in, round result out.
// Illegal moves never reach here (the controller refuses them).
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] p1_move,
  input  logic [1:0] p2_move,
  output logic [1:0] result
);

  // P1 wins on each of the three beating pairs; any other mismatch goes to P2.
  always_comb begin
    result = RES_DRAW;
    if (p1_move != p2_move) begin
      if ((p1_move == MOVE_PAPER    && p2_move == MOVE_STONE)    ||
          (p1_move == MOVE_SCISSORS && p2_move == MOVE_PAPER)    ||
          (p1_move == MOVE_STONE    && p2_move == MOVE_SCISSORS))
        result = RES_P1;
      else
        result = RES_P2;
    end
  end

endmodule

// File: rtl/rps_match_controller.sv
// Best-of-N stone-paper-scissors match sequencer. Collects one move per
// player through valid/ready, judges the round, keeps scores and declares
// the match winner. Optional COLLECT timeout under macro RPS_TIMEOUT_EN.
module rps_match_controller
  import rps_pkg::*;
#(
  parameter  int ROUNDS_TO_WIN  = 2,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int SW             = $clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    p1_move,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic [1:0]    p2_move,
  input  logic          p2_valid,
  output logic          p2_ready,
  output logic [1:0]    result,
  output logic          result_valid,
  output logic [SW-1:0] score_p1,
  output logic [SW-1:0] score_p2,
  output logic          match_done,
  output logic [1:0]    winner,
  output logic          illegal_move
);

  // Reject out-of-range configurations at elaboration.
  if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > 7 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("rps_match_controller: ROUNDS_TO_WIN must be 1..7, TIMEOUT_CYCLES >= 1");
  end

  state_e state;
  move_t  m1_q, m2_q;
  res_t   judge_res, round_res;

  // While in COLLECT, ready high means that player's move is still missing.
  logic acc1, acc2, ill1, ill2, have1, have2;
  assign acc1  = p1_valid & p1_ready & (p1_move != MOVE_ILLEGAL);
  assign acc2  = p2_valid & p2_ready & (p2_move != MOVE_ILLEGAL);
  assign ill1  = p1_valid & p1_ready & (p1_move == MOVE_ILLEGAL);
  assign ill2  = p2_valid & p2_ready & (p2_move == MOVE_ILLEGAL);
  assign have1 = ~p1_ready | acc1;
  assign have2 = ~p2_ready | acc2;

  rps_judge u_judge (
    .p1_move (m1_q),
    .p2_move (m2_q),
    .result  (judge_res)
  );

`ifdef RPS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_q;
  res_t          tmo_res_q;

  // A timed-out round bypasses the judge with the forfeit result.
  always_comb begin
    round_res = tmo_q ? tmo_res_q : judge_res;
  end
`else
  assign round_res = judge_res;
`endif

  // Match FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      m1_q         <= MOVE_STONE;
      m2_q         <= MOVE_STONE;
      p1_ready     <= 1'b0;
      p2_ready     <= 1'b0;
      result       <= RES_DRAW;
      result_valid <= 1'b0;
      score_p1     <= '0;
      score_p2     <= '0;
      match_done   <= 1'b0;
      winner       <= RES_DRAW;
      illegal_move <= 1'b0;
`ifdef RPS_TIMEOUT_EN
      tmo_cnt      <= '0;
      tmo_q        <= 1'b0;
      tmo_res_q    <= RES_DRAW;
`endif
    end else begin
      illegal_move <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_COLLECT;
            score_p1   <= '0;
            score_p2   <= '0;
            m1_q       <= MOVE_STONE;
            m2_q       <= MOVE_STONE;
            p1_ready   <= 1'b1;
            p2_ready   <= 1'b1;
            match_done <= 1'b0;
            winner     <= RES_DRAW;
`ifdef RPS_TIMEOUT_EN
            tmo_cnt    <= '0;
            tmo_q      <= 1'b0;
`endif
          end
        end
        ST_COLLECT: begin
          illegal_move <= ill1 | ill2;
          if (acc1) begin
            m1_q     <= p1_move;
            p1_ready <= 1'b0;
          end
          if (acc2) begin
            m2_q     <= p2_move;
            p2_ready <= 1'b0;
          end
          if (have1 && have2) begin
            state <= ST_JUDGE;
          end
`ifdef RPS_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= ST_JUDGE;
            p1_ready  <= 1'b0;
            p2_ready  <= 1'b0;
            tmo_q     <= 1'b1;
            tmo_res_q <= have1 ? RES_P1 : (have2 ? RES_P2 : RES_DRAW);
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        ST_JUDGE: begin
          state        <= ST_REPORT;
          result       <= round_res;
          result_valid <= 1'b1;
          if (round_res == RES_P1) score_p1 <= score_p1 + SW'(1);
          if (round_res == RES_P2) score_p2 <= score_p2 + SW'(1);
        end
        ST_REPORT: begin
          result_valid <= 1'b0;
          if (score_p1 == SW'(ROUNDS_TO_WIN) || score_p2 == SW'(ROUNDS_TO_WIN)) begin
            state      <= ST_DONE;
            match_done <= 1'b1;
            winner     <= (score_p1 == SW'(ROUNDS_TO_WIN)) ? RES_P1 : RES_P2;
          end else begin
            state    <= ST_COLLECT;
            m1_q     <= MOVE_STONE;
            m2_q     <= MOVE_STONE;
            p1_ready <= 1'b1;
            p2_ready <= 1'b1;
`ifdef RPS_TIMEOUT_EN
            tmo_cnt  <= '0;
            tmo_q    <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_controller.sv
// Self-checking bench for rps_match_controller: a table of hand-written
// rounds, a reset-during-JUDGE sequence, randomized matches against a
// modular-arithmetic reference, and timeout rounds when RPS_TIMEOUT_EN is set.
module tb_rps_match_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] p1_move = 2'b00, p2_move = 2'b00;
  logic       p1_valid = 1'b0, p2_valid = 1'b0;
  logic       p1_ready, p2_ready;
  logic [1:0] result;
  logic       result_valid;
  logic [1:0] score_p1, score_p2;
  logic       match_done;
  logic [1:0] winner;
  logic       illegal_move;

  int n_chk = 0;
  int n_pass = 0;

  rps_match_controller #(.ROUNDS_TO_WIN(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .p1_move(p1_move), .p1_valid(p1_valid), .p1_ready(p1_ready),
    .p2_move(p2_move), .p2_valid(p2_valid), .p2_ready(p2_ready),
    .result(result), .result_valid(result_valid),
    .score_p1(score_p1), .score_p2(score_p2),
    .match_done(match_done), .winner(winner), .illegal_move(illegal_move)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got running, want done)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: (a - b) mod 3 is 0 for a draw, 1 when P1 wins, 2 when P2 wins.
  function automatic logic [1:0] ref_res(input int a, input int b);
    int d;
    d = (a - b + 3) % 3;
    return (d == 0) ? 2'b00 : (d == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic check_zero_outs();
    check("rst_p1_ready", p1_ready, 0);
    check("rst_p2_ready", p2_ready, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_match_done", match_done, 0);
    check("rst_illegal", illegal_move, 0);
    check("rst_result", result, 0);
    check("rst_winner", winner, 0);
    check("rst_score_p1", score_p1, 0);
    check("rst_score_p2", score_p2, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    p1_valid = 0; p2_valid = 0; start = 0;
    rst_n = 0;
    #1 check_zero_outs();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Entered at a negedge; returns at the negedge right after COLLECT entry.
  task automatic start_match();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // One round from COLLECT entry through the cycle after REPORT.
  // P1 offers 11 for 'ill' cycles starting at d1 before its real move.
  task automatic play_round(input logic [1:0] m1, input int d1, input logic [1:0] m2,
                            input int d2, input int ill, input logic [1:0] er,
                            input int es1, input int es2, input bit edone,
                            input logic [1:0] ewin);
    bit a1, a2, pill;
    int c;
    a1 = 0; a2 = 0; pill = 0; c = 0;
    while (!(a1 && a2) && c < 40) begin
      check("p1_ready", p1_ready, !a1);
      check("p2_ready", p2_ready, !a2);
      check("illegal_move", illegal_move, pill);
      p1_valid = (c >= d1);
      p1_move  = (c < d1 + ill) ? 2'b11 : m1;
      p2_valid = (c >= d2);
      p2_move  = m2;
      pill = p1_valid && !a1 && (p1_move == 2'b11);
      @(negedge clk);
      c++;
      if (p1_valid && !a1 && p1_move != 2'b11) a1 = 1;
      if (p2_valid && !a2) a2 = 1;
    end
    check("both_accepted", a1 && a2, 1);
    // JUDGE cycle
    p1_valid = 0; p2_valid = 0;
    check("judge_result_valid", result_valid, 0);
    check("judge_p1_ready", p1_ready, 0);
    check("judge_p2_ready", p2_ready, 0);
    check("judge_illegal", illegal_move, pill);
    @(negedge clk);
    // REPORT cycle
    check("rep_result_valid", result_valid, 1);
    check("rep_result", result, er);
    check("rep_score_p1", score_p1, es1);
    check("rep_score_p2", score_p2, es2);
    check("rep_match_done", match_done, 0);
    @(negedge clk);
    check("post_result_valid", result_valid, 0);
    check("post_match_done", match_done, edone);
    check("post_winner", winner, ewin);
    check("post_p1_ready", p1_ready, !edone);
    check("post_p2_ready", p2_ready, !edone);
  endtask

`ifdef RPS_TIMEOUT_EN
  // Timed-out round: optionally P1 commits on the first COLLECT cycle.
  task automatic tmo_round(input bit offer1, input logic [1:0] er, input int es1, input int es2);
    int n;
    if (offer1) begin p1_move = 2'b00; p1_valid = 1; end
    @(negedge clk);
    p1_valid = 0;
    n = 1;
    while (!result_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", n, 9);
    check("tmo_result", result, er);
    check("tmo_score_p1", score_p1, es1);
    check("tmo_score_p2", score_p2, es2);
    @(negedge clk);
  endtask
`endif

  typedef struct {
    logic [1:0] m1; int d1;
    logic [1:0] m2; int d2;
    int ill;
    logic [1:0] er; int es1; int es2; bit edone; logic [1:0] ewin;
  } vec_t;

  vec_t vecs[4];

  initial begin
    // One scripted match: 1-0, draw, P2 after illegal offer, P2 takes it 1-2.
    vecs[0] = '{2'b00, 0, 2'b10, 0, 0, 2'b01, 1, 0, 1'b0, 2'b00};
    vecs[1] = '{2'b01, 0, 2'b01, 5, 0, 2'b00, 1, 0, 1'b0, 2'b00};
    vecs[2] = '{2'b01, 0, 2'b10, 1, 2, 2'b10, 1, 1, 1'b0, 2'b00};
    vecs[3] = '{2'b00, 2, 2'b01, 0, 0, 2'b10, 1, 2, 1'b1, 2'b10};

    do_reset();
    // IDLE ignores offered moves without start
    p1_valid = 1; p2_valid = 1;
    @(negedge clk);
    check("idle_p1_ready", p1_ready, 0);
    check("idle_illegal", illegal_move, 0);
    p1_valid = 0; p2_valid = 0;

    start_match();
    for (int i = 0; i < 4; i++)
      play_round(vecs[i].m1, vecs[i].d1, vecs[i].m2, vecs[i].d2, vecs[i].ill,
                 vecs[i].er, vecs[i].es1, vecs[i].es2, vecs[i].edone, vecs[i].ewin);

    // Restart from DONE clears scores and reopens both players
    start_match();
    check("restart_score_p1", score_p1, 0);
    check("restart_score_p2", score_p2, 0);
    check("restart_done", match_done, 0);
    check("restart_winner", winner, 0);
    check("restart_p1_ready", p1_ready, 1);
    check("restart_p2_ready", p2_ready, 1);

    // Reset asserted while in JUDGE
    p1_move = 2'b00; p2_move = 2'b10; p1_valid = 1; p2_valid = 1;
    @(negedge clk);
    p1_valid = 0; p2_valid = 0;
    rst_n = 0;
    #1 check_zero_outs();
    @(negedge clk);
    rst_n = 1;
    start_match();
    play_round(2'b00, 0, 2'b10, 0, 0, 2'b01, 1, 0, 1'b0, 2'b00);
    play_round(2'b10, 1, 2'b01, 0, 0, 2'b01, 2, 0, 1'b1, 2'b01);

    // Randomized matches against the reference
    for (int m = 0; m < 6; m++) begin
      int s1, s2, k;
      s1 = 0; s2 = 0; k = 0;
      start_match();
      while (s1 < 2 && s2 < 2 && k < 20) begin
        int a, b, d1, d2, ill;
        logic [1:0] r;
        bit dn;
        a = $urandom_range(0, 2); b = $urandom_range(0, 2);
        d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 3);
        ill = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        r = ref_res(a, b);
        if (r == 2'b01) s1++;
        if (r == 2'b10) s2++;
        dn = (s1 == 2) || (s2 == 2);
        play_round(2'(a), d1, 2'(b), d2, ill, r, s1, s2, dn,
                   !dn ? 2'b00 : (s1 == 2) ? 2'b01 : 2'b10);
        k++;
      end
      if (!(s1 == 2 || s2 == 2)) do_reset();
    end

`ifdef RPS_TIMEOUT_EN
    do_reset();
    start_match();
    tmo_round(1'b1, 2'b01, 1, 0);
    tmo_round(1'b0, 2'b00, 1, 0);
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
